// File: rtl/kappa3_dbg_pkg.sv
// Shared types and helpers for the debug-loadable register bank.
package kappa3_dbg_pkg;

  // Scan controller states: IDLE accepts loads, SCAN shifts the whole bank.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_e;

  // Number of shifts in one complete scan, i.e. total bits held by the bank.
  function automatic int scan_len(input int nreg, input int width);
    return nreg * width;
  endfunction

endpackage

// File: rtl/reg_bank_dbg_scan_ctl.sv
// Scan controller: IDLE/SCAN FSM, shift counter, shift enable and done pulse.
// The FSM state is exported so the top can derive busy and checkers can bind to it.
module reg_bank_dbg_scan_ctl
  import kappa3_dbg_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREG  = 4,
  parameter int CW    = $clog2(NREG * WIDTH + 1)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dbg_mode,
  input  logic        dbg_scan_start,
  output scan_state_e state,
  output logic        shift_en,
  output logic        dbg_done
);

  localparam logic [CW-1:0] SCAN_LEN = CW'(scan_len(NREG, WIDTH));

  logic [CW-1:0] cnt;

  // A shift happens on every SCAN cycle in which debug mode is still held.
  assign shift_en = (state == SCAN) && dbg_mode;

  // FSM with its counter and registered done pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      dbg_done <= 1'b0;
    end else begin
      dbg_done <= 1'b0;
      case (state)
        IDLE: begin
          if (dbg_mode && dbg_scan_start) begin
            state <= SCAN;
            cnt   <= SCAN_LEN;
          end
        end
        SCAN: begin
          if (!dbg_mode) begin
            // Abort: leave the partially shifted bank as it is.
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
              state    <= IDLE;
              dbg_done <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/reg_bank_dbg.sv
// Bank of NREG registers with functional loads, addressed debug write,
// registered debug readback and a serial scan chain through the whole bank.
//
// Handshake note: there is no valid/ready pair here. Loads are level-sampled
// strobes acting on the next rising clock; dbg_scan_start is a one-cycle
// request honoured only in IDLE with dbg_mode=1, dbg_busy covers the SCAN
// state and dbg_done is a one-cycle pulse after the last shift.
module reg_bank_dbg
  import kappa3_dbg_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int NREG  = 4,
  localparam int AW    = $clog2(NREG),
  localparam int CW    = $clog2(NREG * WIDTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREG*WIDTH-1:0] in,
  input  logic [NREG-1:0]       ld,
  output logic [NREG*WIDTH-1:0] out,
  input  logic                  dbg_mode,
  input  logic [AW-1:0]         dbg_addr,
  input  logic [WIDTH-1:0]      dbg_in,
  input  logic                  dbg_ld,
  output logic [WIDTH-1:0]      dbg_rd,
  input  logic                  dbg_scan_start,
  input  logic                  dbg_si,
  output logic                  dbg_so,
  output logic                  dbg_busy,
  output logic                  dbg_done
);

  localparam int NW = NREG * WIDTH;

  // Register i lives in bank_q[i*WIDTH +: WIDTH]; the flat vector is also the
  // scan chain, with dbg_si entering at the top and dbg_so leaving at bit 0.
  logic [NW-1:0]    bank_q;
  logic [WIDTH-1:0] rd_val;
  scan_state_e      scan_state;
  logic             shift_en;

  reg_bank_dbg_scan_ctl #(
    .WIDTH (WIDTH),
    .NREG  (NREG),
    .CW    (CW)
  ) u_scan_ctl (
    .clock          (clock),
    .reset          (reset),
    .dbg_mode       (dbg_mode),
    .dbg_scan_start (dbg_scan_start),
    .state          (scan_state),
    .shift_en       (shift_en),
    .dbg_done       (dbg_done)
  );

  assign out      = bank_q;
  assign dbg_so   = bank_q[0];
  assign dbg_busy = (scan_state == SCAN);

  // Readback mux; addresses beyond the last register read as zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NREG; i++) begin
      if (dbg_addr == AW'(i)) rd_val = bank_q[i*WIDTH +: WIDTH];
    end
  end

  // Register bank update: scan shift, else debug write, else functional loads.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bank_q <= '0;
      dbg_rd <= '0;
    end else begin
      dbg_rd <= rd_val;
      if (shift_en) begin
        bank_q <= {dbg_si, bank_q[NW-1:1]};
      end else if (!dbg_busy) begin
        // While busy (including an abort cycle) all loads are blocked.
        if (dbg_mode) begin
          for (int i = 0; i < NREG; i++) begin
            if (dbg_ld && (dbg_addr == AW'(i))) bank_q[i*WIDTH +: WIDTH] <= dbg_in;
          end
        end else begin
          for (int i = 0; i < NREG; i++) begin
            if (ld[i]) bank_q[i*WIDTH +: WIDTH] <= in[i*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_bank_dbg.sv
// Bench for reg_bank_dbg: a 32x4 instance checked every cycle against a
// behavioural model, plus 4x2 (scan) and 8x3 (address bounds) instances
// checked with hand-computed values.
module tb_reg_bank_dbg;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // ---------------- instance A: WIDTH=32, NREG=4 ----------------
  logic [127:0] a_in = '0;
  logic [3:0]   a_ld = '0;
  logic [127:0] a_out;
  logic         a_mode = 1'b0;
  logic [1:0]   a_addr = '0;
  logic [31:0]  a_din = '0;
  logic         a_dld = 1'b0;
  logic [31:0]  a_rd;
  logic         a_start = 1'b0;
  logic         a_si = 1'b0;
  logic         a_so, a_busy, a_done;

  reg_bank_dbg #(.WIDTH(32), .NREG(4)) u_a (
    .clock(clock), .reset(reset), .in(a_in), .ld(a_ld), .out(a_out),
    .dbg_mode(a_mode), .dbg_addr(a_addr), .dbg_in(a_din), .dbg_ld(a_dld),
    .dbg_rd(a_rd), .dbg_scan_start(a_start), .dbg_si(a_si), .dbg_so(a_so),
    .dbg_busy(a_busy), .dbg_done(a_done)
  );

  // ---------------- instance B: WIDTH=4, NREG=2 ----------------
  logic [7:0] b_in = '0;
  logic [1:0] b_ld = '0;
  logic [7:0] b_out;
  logic       b_mode = 1'b0;
  logic [0:0] b_addr = '0;
  logic [3:0] b_din = '0;
  logic       b_dld = 1'b0;
  logic [3:0] b_rd;
  logic       b_start = 1'b0;
  logic       b_si = 1'b0;
  logic       b_so, b_busy, b_done;

  reg_bank_dbg #(.WIDTH(4), .NREG(2)) u_b (
    .clock(clock), .reset(reset), .in(b_in), .ld(b_ld), .out(b_out),
    .dbg_mode(b_mode), .dbg_addr(b_addr), .dbg_in(b_din), .dbg_ld(b_dld),
    .dbg_rd(b_rd), .dbg_scan_start(b_start), .dbg_si(b_si), .dbg_so(b_so),
    .dbg_busy(b_busy), .dbg_done(b_done)
  );

  // ---------------- instance C: WIDTH=8, NREG=3 ----------------
  logic [23:0] c_in = '0;
  logic [2:0]  c_ld = '0;
  logic [23:0] c_out;
  logic        c_mode = 1'b0;
  logic [1:0]  c_addr = '0;
  logic [7:0]  c_din = '0;
  logic        c_dld = 1'b0;
  logic [7:0]  c_rd;
  logic        c_start = 1'b0;
  logic        c_si = 1'b0;
  logic        c_so, c_busy, c_done;

  reg_bank_dbg #(.WIDTH(8), .NREG(3)) u_c (
    .clock(clock), .reset(reset), .in(c_in), .ld(c_ld), .out(c_out),
    .dbg_mode(c_mode), .dbg_addr(c_addr), .dbg_in(c_din), .dbg_ld(c_dld),
    .dbg_rd(c_rd), .dbg_scan_start(c_start), .dbg_si(c_si), .dbg_so(c_so),
    .dbg_busy(c_busy), .dbg_done(c_done)
  );

  // ---------------- behavioural model of instance A ----------------
  // The bank is a list of four words; a scan treats it as one 128-bit stream
  // in which a new bit enters at the top and everything moves one place down.
  logic [31:0]  m_reg [4];
  logic [31:0]  m_rd;
  logic [127:0] m_all;
  bit           m_busy, m_done;
  int           m_left;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) m_reg[i] = '0;
      m_rd = '0; m_busy = 0; m_done = 0; m_left = 0;
    end else begin
      m_rd   = m_reg[a_addr];
      m_done = 0;
      if (m_busy) begin
        if (a_mode) begin
          m_all = {m_reg[3], m_reg[2], m_reg[1], m_reg[0]};
          m_all = {a_si, m_all[127:1]};
          for (int i = 0; i < 4; i++) m_reg[i] = m_all[i*32 +: 32];
          m_left = m_left - 1;
          if (m_left == 0) begin m_busy = 0; m_done = 1; end
        end else begin
          m_busy = 0; m_left = 0;
        end
      end else if (a_mode) begin
        if (a_dld) m_reg[a_addr] = a_din;
        if (a_start) begin m_busy = 1; m_left = 128; end
      end else begin
        for (int i = 0; i < 4; i++) if (a_ld[i]) m_reg[i] = a_in[i*32 +: 32];
      end
    end
  end

  // Compare process: instance A against the model on every falling edge.
  bit chk_en = 0;
  always @(negedge clock) begin
    if (chk_en) begin
      check("a_out",  a_out,  {m_reg[3], m_reg[2], m_reg[1], m_reg[0]});
      check("a_rd",   a_rd,   m_rd);
      check("a_busy", a_busy, m_busy);
      check("a_done", a_done, m_done);
      check("a_so",   a_so,   m_reg[0][0]);
    end
  end

  // ---------------- scoreboard for instance B scan-out ----------------
  logic [0:0] exp_q[$];

  // ---------------- directed stimulus ----------------
  logic [127:0] pat;
  logic [7:0]   so_bits;
  int           busy_cnt, done_cnt;
  logic [0:0]   e;

  initial begin
    // Reset held.
    tick(); tick();
    chk_en = 1;
    check("rst_out", a_out, 128'h0);
    check("rst_rd", a_rd, 32'h0);
    check("rst_busy", a_busy, 1'b0);
    reset = 1'b1;
    tick();

    // Functional load of registers 0 and 2 only.
    a_ld = 4'b0101;
    a_in = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    tick();
    a_ld = '0;
    check("func_ld", a_out, {32'h0, 32'h33333333, 32'h0, 32'h11111111});

    // Debug write has priority; functional ld ignored; same-cycle read is old.
    a_mode = 1'b1; a_ld = 4'b1111; a_dld = 1'b1; a_addr = 2'd3; a_din = 32'hDEADBEEF;
    tick();
    a_ld = '0; a_dld = 1'b0;
    check("dbg_wr", a_out, {32'hDEADBEEF, 32'h33333333, 32'h0, 32'h11111111});
    check("rd_old", a_rd, 32'h0);
    tick();
    check("rd_new", a_rd, 32'hDEADBEEF);
    a_addr = 2'd2;
    tick();
    check("rd_r2", a_rd, 32'h33333333);

    // Full 128-bit scan loading a known pattern.
    pat = {32'hA5A50F0F, 32'h12345678, 32'hCAFEF00D, 32'h0BADBEEF};
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int k = 0; k < 128; k++) begin
      a_si = pat[k];
      tick();
    end
    check("scan_a_out", a_out, pat);
    check("scan_a_done", a_done, 1'b1);
    check("scan_a_busy", a_busy, 1'b0);
    tick();
    check("scan_a_done_1cyc", a_done, 1'b0);

    // Asynchronous reset in the middle of a scan, between clock edges.
    a_start = 1'b1; a_si = 1'b1;
    tick();
    a_start = 1'b0;
    repeat (5) tick();
    #1 reset = 1'b0;
    #1;
    check("arst_out", a_out, 128'h0);
    check("arst_busy", a_busy, 1'b0);
    check("arst_rd", a_rd, 32'h0);
    a_mode = 1'b0; a_si = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Instance B: 8-bit scan of 0x5/0xA with ones shifted in.
    b_ld = 2'b11; b_in = {4'hA, 4'h5};
    tick();
    b_ld = '0;
    check("b_load", b_out, 8'hA5);
    so_bits = 8'b1010_0101;
    for (int k = 0; k < 8; k++) begin
      e = so_bits[k];
      exp_q.push_back(e);
    end
    b_mode = 1'b1; b_start = 1'b1; b_si = 1'b1;
    tick();
    b_start = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (b_busy) begin
        busy_cnt++;
        if (exp_q.size() == 0) begin
          check("b_so_extra", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("b_so", b_so, e);
        end
      end
      if (b_done) done_cnt++;
    end
    check("b_so_left", exp_q.size(), 0);
    check("b_busy_cnt", busy_cnt, 8);
    check("b_done_cnt", done_cnt, 1);
    check("b_scan_out", b_out, 8'hFF);

    // Instance B: abort after three shifts.
    tick();
    b_mode = 1'b0; b_ld = 2'b11; b_in = {4'hC, 4'h3};
    tick();
    b_ld = '0;
    check("b_load2", b_out, 8'hC3);
    b_mode = 1'b1; b_start = 1'b1; b_si = 1'b0;
    tick();
    b_start = 1'b0;
    repeat (3) tick();
    check("b_part", b_out, 8'h18);
    check("b_busy_mid", b_busy, 1'b1);
    b_mode = 1'b0; b_ld = 2'b01; b_in = 8'h07;
    tick();
    check("b_abort_busy", b_busy, 1'b0);
    check("b_abort_done", b_done, 1'b0);
    check("b_abort_ld_ign", b_out, 8'h18);
    tick();
    b_ld = '0;
    check("b_ld_resume", b_out, 8'h17);

    // Instance C: out-of-range debug write/read and scan start outside debug.
    c_ld = 3'b111; c_in = 24'h332211;
    tick();
    c_ld = '0;
    check("c_load", c_out, 24'h332211);
    c_mode = 1'b1; c_dld = 1'b1; c_addr = 2'd3; c_din = 8'hFF;
    tick();
    c_dld = 1'b0;
    check("c_oob_wr", c_out, 24'h332211);
    check("c_oob_rd", c_rd, 8'h00);
    c_addr = 2'd1;
    tick();
    check("c_rd1", c_rd, 8'h22);
    c_mode = 1'b0; c_start = 1'b1;
    tick();
    c_start = 1'b0;
    check("c_nostart", c_busy, 1'b0);
    tick();
    check("c_nostart2", c_busy, 1'b0);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
